// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared CPU package for the stall/bubble controller.
//   WA_W       : default register-address width
//   stage_tag_t: per-stage write-back tag {valid, wa, we, is_load}
//   BubbleTag  : the all-zero tag a bubble carries
//   mode_e     : RUN/STALL mode, used only to gate the perf counters
package pipe_stall_ctrl_pkg;

    localparam int unsigned WA_W = 5;

    // valid + we + is_load
    localparam int unsigned TagFlagW = 3;

    typedef struct packed {
        logic            valid;
        logic [WA_W-1:0] wa;
        logic            we;
        logic            is_load;
    } stage_tag_t;

    localparam stage_tag_t BubbleTag = '0;

    typedef enum logic {
        StRun,
        StStall
    } mode_e;

    function automatic int unsigned tag_width(input int unsigned wa_w);
        return wa_w + TagFlagW;
    endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// Async-reset pipeline tag register with a bubble select.
//   clk    : clock
//   rstn   : asynchronous active-low reset, clears the tag
//   bubble : capture the all-zero bubble tag instead of d
//   d      : incoming tag
//   q      : held tag
module stage_tag_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= '0;
        end else if (bubble) begin
            q_q <= '0;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble controller and E/M/W destination-register tracker.
// Applies the pause unit's decision (freeze F/D, bubble E) and carries each
// instruction's {wa, we, isLoad} tag down to write-back.
//   clk, rstn                  : clock, async active-low reset
//   i_decValid/Wa/We/IsLoad    : decode-stage instruction tag
//   i_pause                    : hazard stall request (same cycle)
//   i_flush                    : branch/jump taken in E, squash D
//   o_stallF, o_stallD         : hold PC + IF/ID, hold ID/EX inputs
//   o_bubbleE                  : E captures a bubble on this edge
//   o_regWa*/o_regWe*          : destination tag held in E/M/W
//   o_isLoadE                  : E-stage instruction is a load
//   o_stallCycles, o_flushCnt  : saturating perf counters
// Optional feature: define PIPE_STALL_PERF_EN to build the perf counters;
// otherwise both counter outputs are tied to zero.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned WA_W = pipe_stall_ctrl_pkg::WA_W
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_decValid,
    input  logic [WA_W-1:0] i_decWa,
    input  logic            i_decWe,
    input  logic            i_decIsLoad,
    input  logic            i_pause,
    input  logic            i_flush,
    output logic            o_stallF,
    output logic            o_stallD,
    output logic            o_bubbleE,
    output logic [WA_W-1:0] o_regWaE,
    output logic [WA_W-1:0] o_regWaM,
    output logic [WA_W-1:0] o_regWaW,
    output logic            o_regWeE,
    output logic            o_regWeM,
    output logic            o_regWeW,
    output logic            o_isLoadE,
    output logic [31:0]     o_stallCycles,
    output logic [31:0]     o_flushCnt
);

    // Same layout as stage_tag_t, but sized by this instance's WA_W.
    typedef struct packed {
        logic            valid;
        logic [WA_W-1:0] wa;
        logic            we;
        logic            is_load;
    } tag_t;

    localparam int unsigned TagW = tag_width(WA_W);

    tag_t dec_tag;
    tag_t tag_e;
    tag_t tag_m;
    tag_t tag_w;
    logic stall;

    // Flush beats pause: the redirect must not be held off by a stall.
    assign stall     = i_pause & ~i_flush;
    assign o_stallF  = stall;
    assign o_stallD  = stall;
    assign o_bubbleE = i_pause | i_flush | ~i_decValid;

    // Sanitise the decode tag so E/M/W never advertise a write to r0 or a
    // write/load from an empty slot.
    always_comb begin
        dec_tag         = '0;
        dec_tag.valid   = i_decValid;
        dec_tag.wa      = i_decWa;
        dec_tag.we      = i_decValid & i_decWe & (i_decWa != '0);
        dec_tag.is_load = i_decValid & i_decIsLoad;
    end

    stage_tag_reg #(
        .W (TagW)
    ) u_tag_e (
        .clk    (clk),
        .rstn   (rstn),
        .bubble (o_bubbleE),
        .d      (dec_tag),
        .q      (tag_e)
    );

    // Nothing stalls at or after E, so M and W always advance.
    stage_tag_reg #(
        .W (TagW)
    ) u_tag_m (
        .clk    (clk),
        .rstn   (rstn),
        .bubble (1'b0),
        .d      (tag_e),
        .q      (tag_m)
    );

    stage_tag_reg #(
        .W (TagW)
    ) u_tag_w (
        .clk    (clk),
        .rstn   (rstn),
        .bubble (1'b0),
        .d      (tag_m),
        .q      (tag_w)
    );

    assign o_regWaE  = tag_e.wa;
    assign o_regWaM  = tag_m.wa;
    assign o_regWaW  = tag_w.wa;
    assign o_regWeE  = tag_e.we;
    assign o_regWeM  = tag_m.we;
    assign o_regWeW  = tag_w.we;
    assign o_isLoadE = tag_e.is_load;

    logic unused_tags;
    assign unused_tags = ^{tag_e.valid, tag_m.valid, tag_m.is_load, tag_w.valid, tag_w.is_load};

`ifdef PIPE_STALL_PERF_EN
    mode_e       mode_q, mode_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            StRun:   if (stall)  mode_d = StStall;
            StStall: if (!stall) mode_d = StRun;
            default: mode_d = StRun;
        endcase
    end

    // mode_d == StStall exactly when the current cycle is a stall cycle, so
    // the count lands on the edge that ends that cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mode_d == StStall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (i_flush && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q      <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            mode_q      <= mode_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stallCycles = stall_cnt_q;
    assign o_flushCnt    = flush_cnt_q;
`else
    assign o_stallCycles = '0;
    assign o_flushCnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl. Each driven cycle pushes its
// hand-computed expected outputs; a monitor pops and compares on negedge.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_decValid;
    logic [4:0]  i_decWa;
    logic        i_decWe;
    logic        i_decIsLoad;
    logic        i_pause;
    logic        i_flush;
    logic        o_stallF, o_stallD, o_bubbleE;
    logic [4:0]  o_regWaE, o_regWaM, o_regWaW;
    logic        o_regWeE, o_regWeM, o_regWeW;
    logic        o_isLoadE;
    logic [31:0] o_stallCycles, o_flushCnt;

    pipe_stall_ctrl #(
        .WA_W (5)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_decValid    (i_decValid),
        .i_decWa       (i_decWa),
        .i_decWe       (i_decWe),
        .i_decIsLoad   (i_decIsLoad),
        .i_pause       (i_pause),
        .i_flush       (i_flush),
        .o_stallF      (o_stallF),
        .o_stallD      (o_stallD),
        .o_bubbleE     (o_bubbleE),
        .o_regWaE      (o_regWaE),
        .o_regWaM      (o_regWaM),
        .o_regWaW      (o_regWaW),
        .o_regWeE      (o_regWeE),
        .o_regWeM      (o_regWeM),
        .o_regWeW      (o_regWeW),
        .o_isLoadE     (o_isLoadE),
        .o_stallCycles (o_stallCycles),
        .o_flushCnt    (o_flushCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall_f;
        logic        bubble_e;
        logic [4:0]  wa_e, wa_m, wa_w;
        logic        we_e, we_m, we_w, ld_e;
        logic [31:0] stall_cnt, flush_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
        end
    endtask

    // Monitor: inputs settle 1ns after posedge, outputs compared on negedge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "stallF",   32'(o_stallF),  32'(e.stall_f));
            chk(e.name, "stallD",   32'(o_stallD),  32'(e.stall_f));
            chk(e.name, "bubbleE",  32'(o_bubbleE), 32'(e.bubble_e));
            chk(e.name, "waE",      32'(o_regWaE),  32'(e.wa_e));
            chk(e.name, "weE",      32'(o_regWeE),  32'(e.we_e));
            chk(e.name, "isLoadE",  32'(o_isLoadE), 32'(e.ld_e));
            chk(e.name, "waM",      32'(o_regWaM),  32'(e.wa_m));
            chk(e.name, "weM",      32'(o_regWeM),  32'(e.we_m));
            chk(e.name, "waW",      32'(o_regWaW),  32'(e.wa_w));
            chk(e.name, "weW",      32'(o_regWeW),  32'(e.we_w));
            chk(e.name, "stallCyc", o_stallCycles,  e.stall_cnt);
            chk(e.name, "flushCnt", o_flushCnt,     e.flush_cnt);
        end
    end

    // Drive one cycle's inputs and queue what the monitor must see this cycle.
    // Counter expectations are the PERF values; without PERF they are zero.
    task automatic apply(input logic v, input logic [4:0] wa, input logic we, input logic ld,
                         input logic p, input logic f, input string nm,
                         input logic sf, input logic be,
                         input logic [4:0] wae, input logic wee, input logic lde,
                         input logic [4:0] wam, input logic wem,
                         input logic [4:0] waw, input logic wew,
                         input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        i_decValid  = v;
        i_decWa     = wa;
        i_decWe     = we;
        i_decIsLoad = ld;
        i_pause     = p;
        i_flush     = f;
        e.name = nm; e.stall_f = sf; e.bubble_e = be;
        e.wa_e = wae; e.we_e = wee; e.ld_e = lde;
        e.wa_m = wam; e.we_m = wem; e.wa_w = waw; e.we_w = wew;
`ifdef PIPE_STALL_PERF_EN
        e.stall_cnt = sc;
        e.flush_cnt = fc;
`else
        e.stall_cnt = 32'd0 & sc;
        e.flush_cnt = 32'd0 & fc;
`endif
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; i_decValid = 1'b0; i_decWa = '0; i_decWe = 1'b0;
        i_decIsLoad = 1'b0; i_pause = 1'b1; i_flush = 1'b0;

        //          v  wa we ld p  f  name      sF bE waE weE ldE waM weM waW weW sc fc
        next_cycle(); apply(0, 0, 0, 0, 1, 0, "rst1",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); apply(0, 0, 0, 0, 1, 0, "rst2",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); rstn = 1'b1;
        apply(1, 1, 1, 0, 0, 0, "line1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); apply(1, 2, 1, 0, 0, 0, "line2",  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); apply(1, 3, 1, 0, 0, 0, "line3",  0, 0, 2, 1, 0, 1, 1, 0, 0, 0, 0);
        next_cycle(); apply(0, 0, 0, 0, 0, 0, "idle",   0, 1, 3, 1, 0, 2, 1, 1, 1, 0, 0);
        next_cycle(); apply(1, 1, 1, 1, 0, 0, "load",   0, 0, 0, 0, 0, 3, 1, 2, 1, 0, 0);
        next_cycle(); apply(1, 4, 1, 0, 1, 0, "ldpause",1, 1, 1, 1, 1, 0, 0, 3, 1, 0, 0);
        next_cycle(); apply(1, 4, 1, 0, 0, 0, "ldafter",0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        next_cycle(); apply(1, 5, 1, 0, 1, 1, "flushp", 0, 1, 4, 1, 0, 0, 0, 1, 1, 1, 0);
        next_cycle(); apply(1, 6, 1, 0, 0, 0, "flafter",0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1);
        next_cycle(); apply(1, 0, 1, 0, 0, 0, "r0",     0, 0, 6, 1, 0, 0, 0, 4, 1, 1, 1);
        next_cycle(); apply(0, 0, 0, 0, 0, 0, "r0chk",  0, 1, 0, 0, 0, 6, 1, 0, 0, 1, 1);
        next_cycle(); apply(0, 0, 0, 0, 1, 0, "nvpause",1, 1, 0, 0, 0, 0, 0, 6, 1, 1, 1);
        next_cycle(); apply(0, 0, 0, 0, 1, 0, "pause2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        next_cycle(); apply(0, 0, 0, 0, 0, 0, "unpause",0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        next_cycle(); apply(1, 7, 1, 1, 0, 0, "pre_rst",0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        // E has just captured wa=7; async reset must clear it before negedge.
        next_cycle(); rstn = 1'b0;
        apply(0, 0, 0, 0, 1, 0, "midrst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); rstn = 1'b1;
        apply(1, 9, 1, 0, 0, 0, "postrst",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); apply(0, 0, 0, 0, 0, 0, "post2",  0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
        next_cycle();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        apply(0, 0, 0, 0, 1, 0, "sat0",   1, 1, 0, 0, 0, 9, 1, 0, 0, 32'hFFFF_FFFE, 0);
        next_cycle(); apply(0, 0, 0, 0, 1, 0, "sat1", 1, 1, 0, 0, 0, 0, 0, 9, 1, 32'hFFFF_FFFF, 0);
        next_cycle(); apply(0, 0, 0, 0, 1, 0, "sat2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
        next_cycle(); apply(0, 0, 0, 0, 0, 0, "sat3", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
